// File: rtl/shared_dff_reg_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter around the negative-edge register:
// FSM state encodings and the default data width.
package shared_dff_reg_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // 2'b11 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_ACK   = 2'b10
  } arb_state_e;

endpackage

// File: rtl/shared_dff_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter: two four-phase write ports
// plus the register contents and arbiter status.
interface shared_dff_reg_arbiter_if
  import shared_dff_reg_arbiter_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] NQ;
  logic             owner;
  logic             busy;

  modport master (
    output req0, req1, data0, data1,
    input  ack0, ack1, Q, NQ, owner, busy
  );

  modport slave (
    input  req0, req1, data0, data1,
    output ack0, ack1, Q, NQ, owner, busy
  );

endinterface

// File: rtl/shared_dff_reg_arbiter_neg_edge_reg_en.sv
// WIDTH-bit falling-edge D register with load enable and asynchronous active-low clear;
// provides both true and complemented outputs.
module neg_edge_reg_en #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq
);

  // storage: loads d on the falling edge when enabled, clears asynchronously
  always_ff @(negedge clock or negedge reset_b) begin
    if (!reset_b) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

  assign nq = ~q;

endmodule

// File: rtl/shared_dff_reg_arbiter.sv
// Round-robin arbiter granting two four-phase requesters write access to one
// shared negative-edge register; all state moves on the falling clock edge.
module shared_dff_reg_arbiter
  import shared_dff_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_b,
  shared_dff_reg_arbiter_if.slave  bus
);

  arb_state_e       state;
  arb_state_e       next_state;
  logic             owner;
  logic             next_owner;
  logic             last;
  logic             next_last;
  logic             ack0;
  logic             next_ack0;
  logic             ack1;
  logic             next_ack1;
  logic             busy;
  logic             next_busy;
  logic             load;
  logic             req_own;
  logic [WIDTH-1:0] wdata;

  assign req_own = owner ? bus.req1 : bus.req0;
  assign wdata   = owner ? bus.data1 : bus.data0;

  // FSM state, grant bookkeeping and registered handshake outputs
  always_ff @(negedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      last  <= next_last;
      ack0  <= next_ack0;
      ack1  <= next_ack1;
      busy  <= next_busy;
    end
  end

  // next-state logic: arbitrate in IDLE, write once in WRITE, hold ack until release
  always_comb begin
    next_state = state;
    next_owner = owner;
    next_last  = last;
    next_ack0  = ack0;
    next_ack1  = ack1;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          next_owner = ~last;
          next_state = ST_WRITE;
        end else if (bus.req0) begin
          next_owner = 1'b0;
          next_state = ST_WRITE;
        end else if (bus.req1) begin
          next_owner = 1'b1;
          next_state = ST_WRITE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (req_own) begin
          load       = 1'b1;
          next_ack0  = ~owner;
          next_ack1  = owner;
          next_state = ST_ACK;
        end else begin
          // aborted request: nothing written and the round-robin pointer is kept
          next_state = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!req_own) begin
          next_ack0  = 1'b0;
          next_ack1  = 1'b0;
          next_last  = owner;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_ACK;
        end
      end
      default: begin
        next_ack0  = 1'b0;
        next_ack1  = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
    next_busy = (next_state != ST_IDLE);
  end

  neg_edge_reg_en #(.WIDTH(WIDTH)) u_reg (
    .clock   (clock),
    .reset_b (reset_b),
    .en      (load),
    .d       (wdata),
    .q       (bus.Q),
    .nq      (bus.NQ)
  );

  assign bus.ack0  = ack0;
  assign bus.ack1  = ack1;
  assign bus.owner = owner;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_shared_dff_reg_arbiter.sv
// Directed bench for shared_dff_reg_arbiter: a vector table for write/tie/alternation
// plus hand-written abort, frozen-data and mid-transaction reset sequences.
module tb_shared_dff_reg_arbiter;

  logic clock;
  logic reset_b;
  int   total;
  int   bad;

  shared_dff_reg_arbiter_if #(.WIDTH(4)) bus_if ();

  shared_dff_reg_arbiter #(.WIDTH(4)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus_if)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    logic       rb;
    logic       r0;
    logic       r1;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       a0;
    logic       a1;
    logic [3:0] q;
    logic       own;
    logic       bsy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic rb, logic r0, logic r1, logic [3:0] d0, logic [3:0] d1,
                              logic a0, logic a1, logic [3:0] q, logic own, logic bsy);
    vec_t v;
    v.rb = rb; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.a0 = a0; v.a1 = a1; v.q = q; v.own = own; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [3:0] d0, input logic [3:0] d1);
    bus_if.req0  = r0;
    bus_if.req1  = r1;
    bus_if.data0 = d0;
    bus_if.data1 = d1;
  endtask

  // one falling (active) edge, then sample just after the following rising edge
  task automatic step();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic a0, input logic a1, input logic [3:0] q,
                         input logic own, input logic bsy);
    chk({tag, ".ack0"}, {3'b000, bus_if.ack0}, {3'b000, a0});
    chk({tag, ".ack1"}, {3'b000, bus_if.ack1}, {3'b000, a1});
    chk({tag, ".Q"},    bus_if.Q, q);
    chk({tag, ".NQ"},   bus_if.NQ, ~q);
    chk({tag, ".busy"}, {3'b000, bus_if.busy}, {3'b000, bsy});
    if (bsy) chk({tag, ".owner"}, {3'b000, bus_if.owner}, {3'b000, own});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 4'b1010, 4'b0000, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b1);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0);

    // reset held from t=0 with a pending request: nothing may be written
    reset_b = 1'b0;
    drive(1'b1, 1'b0, 4'b1111, 4'b0000);
    #1;
    chk_all("rst0", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("rst_hold", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    end

    for (int i = 0; i < 13; i++) begin
      reset_b = tbl[i].rb;
      drive(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].a0, tbl[i].a1, tbl[i].q, tbl[i].own, tbl[i].bsy);
    end

    // abort by requester 1 after a fresh reset; the following tie still goes to 0
    reset_b = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    step();
    reset_b = 1'b1;
    drive(1'b0, 1'b1, 4'b0000, 4'b0110);
    step();
    chk_all("abort_grant", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 4'b0110);
    step();
    chk_all("abort_drop", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'b0101, 4'b0110);
    step();
    chk_all("abort_tie", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step();
    chk_all("tie_write", 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1);

    // data changes while acknowledged must not reach Q; req1 stays ignored
    drive(1'b1, 1'b1, 4'b1110, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("ack_frozen", 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 4'b1110, 4'b0110);
    step();
    chk_all("frozen_rel", 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);

    // asynchronous reset in the middle of an acknowledged write by requester 1
    drive(1'b0, 1'b1, 4'b0000, 4'b1001);
    step();
    chk_all("mid_grant", 1'b0, 1'b0, 4'b0101, 1'b1, 1'b1);
    step();
    chk_all("mid_ack", 1'b0, 1'b1, 4'b1001, 1'b1, 1'b1);
    #1;
    reset_b = 1'b0;
    #1;
    chk_all("mid_reset", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'b0111, 4'b1000);
    reset_b = 1'b1;
    step();
    chk_all("post_rst_tie", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step();
    chk_all("post_rst_wr", 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
